reg_demux_decoded: RTL
======================

Name: reg_demux_decoded

Overview:
- Routes one register-bus initiator to one of `NoPorts` register-bus targets. The target is chosen by decoding the request address against a rule table.
- Fills the opposite role to the register-bus arbiter: one upstream initiator fanned out to many downstream targets.
- Registers the request path and the response path.
- Answers unmapped addresses itself with an error response.
- Aborts a hung target after a bounded wait.

Parameters:
- NoPorts, 2, number of downstream targets (>=1).
- NoRules, 2, number of address-map rules (>=1).
- AW, 32, address width.
- DW, 32, data width; wstrb width is DW/8.
- TimeoutCycles, 256, maximum cycles to wait for target ready (>=1).
- req_t, logic, register-bus request struct: addr, write, wdata, wstrb, valid.
- rsp_t, logic, register-bus response struct: rdata, error, ready.
- rule_t, logic, address rule struct: idx [$clog2(NoPorts)], start_addr [AW], end_addr [AW].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- addr_map_i  in  NoRules x rule_t  address map; quasi-static.
- in_req_i  in  req_t  upstream request.
- in_rsp_o  out  rsp_t  upstream response.
- out_req_o  out  NoPorts x req_t  downstream requests.
- out_rsp_i  in  NoPorts x rsp_t  downstream responses.
- timeout_o  out  1  one-cycle pulse when a target access is aborted.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - FSM goes to IDLE.
  - All out_req_o valid = 0; in_rsp_o.ready = 0; in_rsp_o.rdata = 0; in_rsp_o.error = 0; timeout_o = 0.
  - Latched payload, port index and timeout counter cleared.
  - Reset mid-transaction drops any outstanding access without a response; the initiator must re-issue it.
- Decode (combinational):
  - Rule r matches when start_addr <= addr < end_addr (end exclusive, unsigned).
  - The lowest-numbered matching rule wins.
  - A match whose idx >= NoPorts is treated as a decode miss.
- FSM IDLE:
  - in_req_i.valid = 1 and decode hit → latch addr/write/wdata/wstrb and the port index; clear the counter; go to ACCESS.
  - in_req_i.valid = 1 and decode miss → go to ERR.
  - No other state change.
- FSM ACCESS:
  - out_req_o[idx] is driven from the latched payload with valid = 1; all other ports have valid = 0.
  - Downstream payload stays stable until ready.
  - out_rsp_i[idx].ready = 1 → capture rdata and error; go to RESP.
  - Otherwise the counter increments. When the counter reaches TimeoutCycles-1 without ready: deassert valid next cycle, pulse timeout_o, go to TOUT.
  - Ready arriving in the same cycle as the counter limit counts as success.
- FSM RESP:
  - in_rsp_o.ready = 1 for exactly one cycle, with the captured rdata and error.
  - Go to IDLE.
- FSM ERR and TOUT:
  - in_rsp_o.ready = 1 for one cycle with error = 1 and rdata = 0.
  - Go to IDLE.
- Outside RESP/ERR/TOUT, in_rsp_o.ready = 0 and rdata/error = 0.
- Latency:
  - Request valid at cycle T → downstream valid at T+1.
  - Target ready at T+k (k>=1) → upstream ready at T+k+1.
  - Decode miss → upstream ready at T+1.
- Only one transaction is outstanding at a time. The initiator holds valid and payload stable until ready (register-bus rule).
- The block ignores upstream payload changes after latching.
- After the one-cycle response pulse, a new request is accepted in IDLE on the following cycle. There is no back-to-back acceptance in the response cycle.
- addr_map_i changes are sampled only at decode in IDLE.

Decomposition:
- Shared package reg_demux_pkg holds:
  - state enum: IDLE, ACCESS, RESP, ERR, TOUT;
  - error rdata constant 0;
  - a rule-typedef macro alongside the existing register-bus typedef macros.
- Sub-module reg_addr_decode (combinational), reusable by other interconnect blocks:
  - inputs: addr, addr_map;
  - outputs: idx, hit.
- The FSM, payload registers and timeout counter stay in the top module.

Test Plan:
- Map: rule0 = [0x0000,0x1000)→port0, rule1 = [0x1000,0x2000)→port1. Write 0x1004, data 0xCAFEF00D, strb 0xF; port1 ready after 2 cycles → out_req_o[1] valid at T+1 with the same payload; port0 never valid; in_rsp_o.ready at T+4, error = 0.
- Read 0x0010; port0 returns rdata 0x12345678, error = 0, ready immediately → upstream ready at T+2 with rdata 0x12345678.
- Read 0x3000 (unmapped) → no downstream valid; in_rsp_o.ready at T+1 with error = 1 and rdata = 0.
- Overlapping rules, rule0 = [0,0x2000)→port1 and rule1 = [0x1000,0x2000)→port0; access 0x1800 → routed to port1.
- TimeoutCycles = 4, port0 never ready → valid for 4 cycles, then timeout_o pulses once; error response with rdata 0; next request is serviced normally.
- rst_i asserted during ACCESS → next cycle all valid = 0, in_rsp_o.ready = 0, FSM in IDLE; a re-issued request completes correctly.

Source files
------------

// File: rtl/reg_demux_pkg.sv
// reg_demux_pkg: register-bus typedef macros, demux FSM states and shared constants
`ifndef REG_BUS_TYPEDEF_REQ
`define REG_BUS_TYPEDEF_REQ(req_t, addr_t, data_t, strb_t) typedef struct packed { addr_t addr; logic write; data_t wdata; strb_t wstrb; logic valid; } req_t;
`endif
`ifndef REG_BUS_TYPEDEF_RSP
`define REG_BUS_TYPEDEF_RSP(rsp_t, data_t) typedef struct packed { data_t rdata; logic error; logic ready; } rsp_t;
`endif
`ifndef REG_RULE_TYPEDEF
`define REG_RULE_TYPEDEF(rule_t, idx_t, addr_t) typedef struct packed { idx_t idx; addr_t start_addr; addr_t end_addr; } rule_t;
`endif

package reg_demux_pkg;
   typedef enum logic [2:0] {IDLE, ACCESS, RESP, ERR, TOUT} state_e;
   localparam logic [31:0] ErrRdata = 32'h0;
   typedef logic [31:0] reg_addr_t;
   typedef logic [31:0] reg_data_t;
   typedef logic [3:0]  reg_strb_t;
   typedef logic [0:0]  reg_idx_t;
   `REG_BUS_TYPEDEF_REQ(reg_req_t, reg_addr_t, reg_data_t, reg_strb_t)
   `REG_BUS_TYPEDEF_RSP(reg_rsp_t, reg_data_t)
   `REG_RULE_TYPEDEF(reg_rule_t, reg_idx_t, reg_addr_t)
endpackage

// File: rtl/reg_addr_decode.sv
// reg_addr_decode: maps an address to a port index via a first-match rule table
module reg_addr_decode
   import reg_demux_pkg::*;
#(
   parameter int unsigned NoPorts = 2,
   parameter int unsigned NoRules = 2,
   parameter int unsigned AW      = 32,
   parameter int unsigned IdxW    = NoPorts > 1 ? $clog2(NoPorts) : 1,
   parameter type         rule_t  = reg_rule_t
)(
   input  logic [AW-1:0]   addr_i,
   input  rule_t           addr_map_i [NoRules],
   output logic [IdxW-1:0] idx_o,
   output logic            hit_o
);
   // Scan from the top so the lowest-numbered match is the one left standing.
   always_comb begin
      idx_o = '0;
      hit_o = 1'b0;
      for (int r = NoRules - 1; r >= 0; r--) begin
         if (addr_i >= addr_map_i[r].start_addr && addr_i < addr_map_i[r].end_addr) begin
            idx_o = IdxW'(addr_map_i[r].idx);
            hit_o = int'(addr_map_i[r].idx) < int'(NoPorts);
         end
      end
   end
endmodule

// File: rtl/reg_demux_decoded.sv
// reg_demux_decoded: one register-bus initiator fanned out to NoPorts targets by address decode
module reg_demux_decoded
   import reg_demux_pkg::*;
#(
   parameter int unsigned NoPorts       = 2,
   parameter int unsigned NoRules       = 2,
   parameter int unsigned AW            = 32,
   parameter int unsigned DW            = 32,
   parameter int unsigned TimeoutCycles = 256,
   parameter type         req_t         = reg_req_t,
   parameter type         rsp_t         = reg_rsp_t,
   parameter type         rule_t        = reg_rule_t
)(
   input  logic  clk_i,
   input  logic  rst_i,
   input  rule_t addr_map_i [NoRules],
   input  req_t  in_req_i,
   output rsp_t  in_rsp_o,
   output req_t  out_req_o [NoPorts],
   input  rsp_t  out_rsp_i [NoPorts],
   output logic  timeout_o
);
   localparam int unsigned IdxW = NoPorts > 1 ? $clog2(NoPorts) : 1;
   localparam int unsigned CntW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;

   state_e          state_q, state_d;
   req_t            req_q, req_d;
   logic [IdxW-1:0] idx_q, idx_d, dec_idx;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            error_q, error_d, dec_hit;

   reg_addr_decode #(
      .NoPorts (NoPorts),
      .NoRules (NoRules),
      .AW      (AW),
      .IdxW    (IdxW),
      .rule_t  (rule_t)
   ) i_decode (
      .addr_i     (in_req_i.addr),
      .addr_map_i (addr_map_i),
      .idx_o      (dec_idx),
      .hit_o      (dec_hit)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            if (in_req_i.valid && dec_hit) begin
               req_d       = in_req_i;
               req_d.valid = 1'b0;
               idx_d       = dec_idx;
               cnt_d       = '0;
               state_d     = ACCESS;
            end else if (in_req_i.valid) begin
               state_d = ERR;
            end
         end
         ACCESS: begin
            // Ready wins over the timeout limit when both land in the same cycle.
            if (out_rsp_i[idx_q].ready) begin
               rdata_d = out_rsp_i[idx_q].rdata;
               error_d = out_rsp_i[idx_q].error;
               state_d = RESP;
            end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               state_d = TOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_rsp_o       = '0;
      in_rsp_o.ready = state_q == RESP || state_q == ERR || state_q == TOUT;
      in_rsp_o.rdata = state_q == RESP ? rdata_q : DW'(ErrRdata);
      in_rsp_o.error = state_q == RESP ? error_q : (state_q == ERR || state_q == TOUT);
      for (int p = 0; p < int'(NoPorts); p++) begin
         out_req_o[p]       = req_q;
         out_req_o[p].valid = state_q == ACCESS && idx_q == IdxW'(p);
      end
      timeout_o = state_q == TOUT;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end
endmodule
